// File: rtl/min_max_display.sv
// LED bar driver: shows a value inside a [min, max] window, as a linear bar, or as a lamp test.
// The LED vector is registered once, so it follows the sampled inputs by one clock.
module min_max_display #(
  parameter int VALSIZE = 4,
  parameter int ERRNO   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic                  osc_i,
  input  logic [VALSIZE-1:0]    val_i,
  output logic [2**VALSIZE-1:0] leds_o
);

  localparam int N = 2**VALSIZE;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_LINEAR = 2'b01;
  localparam logic [1:0] MODE_OFF    = 2'b10;
  localparam logic [1:0] MODE_ON     = 2'b11;

  logic [N-1:0] w_leds_next;
  logic         w_osc;
  logic         w_in_window;
  logic [N-1:0] r_leds;

  assign w_osc       = (ERRNO == 2) ? 1'b1 : osc_i;
  assign w_in_window = (min_i <= val_i) && (val_i <= max_i);

  // Each LED is decided independently from its own index, so no shift can wrap past N-1.
  always_comb begin
    w_leds_next = '0;
    case (com_i)
      MODE_NORMAL: begin
        if (w_in_window) begin
          for (int i = 0; i < N; i++) begin
            if ((VALSIZE'(i) >= min_i) && (VALSIZE'(i) <= val_i)) begin
              w_leds_next[i] = !((ERRNO == 1) && (VALSIZE'(i) == val_i));
            end else if ((VALSIZE'(i) > val_i) && (VALSIZE'(i) <= max_i)) begin
              w_leds_next[i] = w_osc;
            end
          end
        end
      end
      MODE_LINEAR: begin
        for (int i = 0; i < N; i++) begin
          if (ERRNO == 3) begin
            w_leds_next[i] = (VALSIZE'(i) < val_i);
          end else begin
            w_leds_next[i] = (VALSIZE'(i) <= val_i);
          end
        end
      end
      MODE_OFF: w_leds_next = '0;
      MODE_ON:  w_leds_next = '1;
      default:  w_leds_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_leds <= '0;
    end else begin
      r_leds <= w_leds_next;
    end
  end

  assign leds_o = r_leds;

endmodule

// File: tb/tb_min_max_display.sv
// Bench for min_max_display (VALSIZE=4): directed cases plus randomized traffic
// checked against a mask-arithmetic reference model.
module tb_min_max_display;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  com_i;
  logic [3:0]  max_i;
  logic [3:0]  min_i;
  logic        osc_i;
  logic [3:0]  val_i;
  logic [15:0] leds_o;

  int n_tests;
  int n_fail;

  min_max_display #(.VALSIZE(4), .ERRNO(0)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .com_i  (com_i),
    .max_i  (max_i),
    .min_i  (min_i),
    .osc_i  (osc_i),
    .val_i  (val_i),
    .leds_o (leds_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: build the bar from contiguous bit masks.
  function automatic logic [15:0] model(input logic [1:0] com, input int mn, input int mx,
                                        input int v, input logic osc);
    int ones;
    int oscm;
    case (com)
      2'b00: begin
        if (v < mn || v > mx) return 16'h0000;
        ones = ((1 << (v + 1)) - 1) & ~((1 << mn) - 1);
        oscm = osc ? (((1 << (mx + 1)) - 1) & ~((1 << (v + 1)) - 1)) : 0;
        return 16'(ones | oscm);
      end
      2'b01:   return 16'((1 << (v + 1)) - 1);
      2'b10:   return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic drive(input logic [1:0] c, input int mn, input int mx, input int v,
                       input logic o);
    @(negedge clk_i);
    com_i = c;
    min_i = 4'(mn);
    max_i = 4'(mx);
    val_i = 4'(v);
    osc_i = o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", leds_o, 16'h0000);
    end
    drive(2'b11, 0, 15, 15, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", leds_o, 16'h0000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (leds_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_release_on: got %h expected %h", leds_o, 16'hFFFF);
    end
    // Asynchronous assertion mid-cycle must clear without a clock edge.
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", leds_o, 16'h0000);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_normal;
    drive(2'b00, 3, 12, 8, 1'b1);
    n_tests++;
    if (leds_o !== 16'h1FF8) begin
      n_fail++;
      $display("FAIL normal_osc1: got %h expected %h", leds_o, 16'h1FF8);
    end
    drive(2'b00, 3, 12, 8, 1'b0);
    n_tests++;
    if (leds_o !== 16'h01F8) begin
      n_fail++;
      $display("FAIL normal_osc0: got %h expected %h", leds_o, 16'h01F8);
    end
    drive(2'b00, 0, 15, 15, 1'b1);
    n_tests++;
    if (leds_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL normal_full: got %h expected %h", leds_o, 16'hFFFF);
    end
    drive(2'b00, 2, 15, 4, 1'b1);
    n_tests++;
    if (leds_o !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL normal_max15: got %h expected %h", leds_o, 16'hFFFC);
    end
  endtask

  task automatic test_out_of_window;
    drive(2'b00, 3, 12, 2, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL window_below: got %h expected %h", leds_o, 16'h0000);
    end
    drive(2'b00, 3, 12, 13, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL window_above: got %h expected %h", leds_o, 16'h0000);
    end
    drive(2'b00, 9, 4, 6, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL window_inverted: got %h expected %h", leds_o, 16'h0000);
    end
    drive(2'b00, 5, 5, 5, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0020) begin
      n_fail++;
      $display("FAIL window_degenerate: got %h expected %h", leds_o, 16'h0020);
    end
  endtask

  task automatic test_linear;
    drive(2'b01, 0, 15, 15, 1'b0);
    n_tests++;
    if (leds_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL linear_full: got %h expected %h", leds_o, 16'hFFFF);
    end
    drive(2'b01, 0, 15, 0, 1'b0);
    n_tests++;
    if (leds_o !== 16'h0001) begin
      n_fail++;
      $display("FAIL linear_zero: got %h expected %h", leds_o, 16'h0001);
    end
    drive(2'b01, 7, 15, 3, 1'b1);
    n_tests++;
    if (leds_o !== 16'h000F) begin
      n_fail++;
      $display("FAIL linear_ignore_min: got %h expected %h", leds_o, 16'h000F);
    end
  endtask

  task automatic test_lamp;
    drive(2'b10, 3, 12, 8, 1'b1);
    n_tests++;
    if (leds_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL lamp_off: got %h expected %h", leds_o, 16'h0000);
    end
    drive(2'b11, 9, 4, 0, 1'b0);
    n_tests++;
    if (leds_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL lamp_on: got %h expected %h", leds_o, 16'hFFFF);
    end
  endtask

  task automatic test_random;
    int mn;
    int mx;
    int v;
    logic [1:0] c;
    logic o;
    logic [15:0] exp_leds;
    for (int k = 0; k < 1000; k++) begin
      mn = int'($urandom_range(14, 0));
      mx = int'($urandom_range(15, mn + 1));
      v  = int'($urandom_range(mx, mn));
      c  = 2'($urandom_range(3, 0));
      o  = 1'($urandom_range(1, 0));
      exp_leds = model(c, mn, mx, v, o);
      drive(c, mn, mx, v, o);
      n_tests++;
      if (leds_o !== exp_leds) begin
        n_fail++;
        $display("FAIL random[%0d] com=%0d min=%0d max=%0d val=%0d osc=%0b: got %h expected %h",
                 k, c, mn, mx, v, o, leds_o, exp_leds);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_ni  = 1'b0;
    com_i   = 2'b00;
    min_i   = 4'd0;
    max_i   = 4'd0;
    val_i   = 4'd0;
    osc_i   = 1'b0;
    test_reset;
    test_normal;
    test_out_of_window;
    test_linear;
    test_lamp;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
